// File: rtl/draw_mux_pkg.sv
// Shared types and helpers for the draw-layer multiplexers of the VGA pipeline.
package draw_mux_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/draw_priority_enc.sv
// Combinational lowest-index-wins priority encoder with a "two or more set" flag.
module draw_priority_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     eff,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic             multi
);

  always_comb begin
    valid = |eff;
    index = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (eff[i]) index = IDX_W'(i);
    end
    // Clearing the lowest set bit leaves something only when popcount >= 2.
    multi = |(eff & (eff - N'(1)));
  end

endmodule

// File: rtl/draw_layer_mux.sv
// N-channel priority draw mux with layer-enable mask, selected-channel index
// and frame-stable overlap bookkeeping. Free-running: one pixel per clock, no stall.
module draw_layer_mux
  import draw_mux_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int COORD_W = draw_mux_pkg::COORD_W
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic [NUM_CH*COORD_W-1:0]   offsetX,
  input  logic [NUM_CH*COORD_W-1:0]   offsetY,
  input  logic [NUM_CH-1:0]           drawRequest,
  input  logic [NUM_CH-1:0]           layerEnable,
  input  logic                        startOfFrame,
  output logic [COORD_W-1:0]          outOffsetX,
  output logic [COORD_W-1:0]          outOffsetY,
  output logic                        outDrawRequest,
  output logic [ch_w(NUM_CH)-1:0]     outChannel,
  output logic [NUM_CH-1:0]           overlapMask,
  output logic                        overlapAny
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [NUM_CH-1:0]  eff;
  logic               sel_valid;
  logic [CH_W-1:0]    sel_idx;
  logic               sel_multi;
  logic [COORD_W-1:0] sel_x;
  logic [COORD_W-1:0] sel_y;
  logic [NUM_CH-1:0]  hit;
  logic [NUM_CH-1:0]  acc;

  // A disabled layer is indistinguishable from one that is not requesting.
  assign eff = drawRequest & layerEnable;

  draw_priority_enc #(
    .N     (NUM_CH),
    .IDX_W (CH_W)
  ) u_enc (
    .eff   (eff),
    .valid (sel_valid),
    .index (sel_idx),
    .multi (sel_multi)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_valid && (sel_idx == CH_W'(i))) begin
        sel_x = offsetX[i*COORD_W +: COORD_W];
        sel_y = offsetY[i*COORD_W +: COORD_W];
      end
    end
  end

  assign hit = sel_multi ? eff : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      outOffsetX     <= '0;
      outOffsetY     <= '0;
      outDrawRequest <= 1'b0;
      outChannel     <= '0;
    end else begin
      outOffsetX     <= sel_x;
      outOffsetY     <= sel_y;
      outDrawRequest <= sel_valid;
      outChannel     <= sel_valid ? sel_idx : '0;
    end
  end

  // The startOfFrame pixel already belongs to the new frame, so its hit
  // seeds the accumulator instead of landing in the snapshot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc         <= '0;
      overlapMask <= '0;
      overlapAny  <= 1'b0;
    end else if (startOfFrame) begin
      overlapMask <= acc;
      overlapAny  <= |acc;
      acc         <= hit;
    end else begin
      acc         <= acc | hit;
    end
  end

endmodule

// File: tb/tb_draw_layer_mux.sv
// Directed bench for draw_layer_mux (NUM_CH=4, COORD_W=11).
module tb_draw_layer_mux;
  import draw_mux_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CW     = 11;
  localparam int CH_W   = 2;
  localparam int W      = 1 + CH_W + CW + CW;

  logic                 clk;
  logic                 resetN;
  logic [NUM_CH*CW-1:0] offsetX;
  logic [NUM_CH*CW-1:0] offsetY;
  logic [NUM_CH-1:0]    drawRequest;
  logic [NUM_CH-1:0]    layerEnable;
  logic                 startOfFrame;
  logic [CW-1:0]        outOffsetX;
  logic [CW-1:0]        outOffsetY;
  logic                 outDrawRequest;
  logic [CH_W-1:0]      outChannel;
  logic [NUM_CH-1:0]    overlapMask;
  logic                 overlapAny;

  int passed;
  int total;
  logic [W-1:0] exp_q[$];

  draw_layer_mux #(.NUM_CH(NUM_CH), .COORD_W(CW)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .drawRequest    (drawRequest),
    .layerEnable    (layerEnable),
    .startOfFrame   (startOfFrame),
    .outOffsetX     (outOffsetX),
    .outOffsetY     (outOffsetY),
    .outDrawRequest (outDrawRequest),
    .outChannel     (outChannel),
    .overlapMask    (overlapMask),
    .overlapAny     (overlapAny)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y);
    offsetX[i*CW +: CW] = x;
    offsetY[i*CW +: CW] = y;
  endtask

  // Drive one pixel, then compare the registered triple against the hand value.
  task automatic pix(input string tag, input logic [3:0] dr, input logic [3:0] le, input logic sof,
                     input logic e_dr, input logic [CH_W-1:0] e_ch,
                     input logic [CW-1:0] e_x, input logic [CW-1:0] e_y);
    logic [W-1:0] e;
    drawRequest  = dr;
    layerEnable  = le;
    startOfFrame = sof;
    exp_q.push_back({e_dr, e_ch, e_x, e_y});
    step();
    e = exp_q.pop_front();
    check({tag, ".dr"}, 32'(outDrawRequest), 32'(e[W-1]));
    check({tag, ".ch"}, 32'(outChannel), 32'(e[2*CW +: CH_W]));
    check({tag, ".x"},  32'(outOffsetX), 32'(e[CW +: CW]));
    check({tag, ".y"},  32'(outOffsetY), 32'(e[0 +: CW]));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) pix("idle", 4'b0000, 4'b1111, 1'b0, 1'b0, 2'd0, 11'd0, 11'd0);
  endtask

  task automatic check_ovl(input string tag, input logic [3:0] e_mask, input logic e_any);
    check({tag, ".mask"}, 32'(overlapMask), 32'(e_mask));
    check({tag, ".any"},  32'(overlapAny),  32'(e_any));
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    resetN       = 1'b0;
    offsetX      = '0;
    offsetY      = '0;
    drawRequest  = '0;
    layerEnable  = '1;
    startOfFrame = 1'b0;
    set_ch(0, 11'd11,  11'd22);
    set_ch(1, 11'd100, 11'd50);
    set_ch(2, 11'd300, 11'd400);
    set_ch(3, 11'd7,   11'd9);

    // 1. Reset held while inputs toggle
    for (int k = 0; k < 4; k++) begin
      drawRequest  = 4'($urandom_range(1, 15));
      startOfFrame = 1'($urandom_range(0, 1));
      step();
    end
    check("rst.dr", 32'(outDrawRequest), 32'd0);
    check("rst.ch", 32'(outChannel), 32'd0);
    check("rst.x",  32'(outOffsetX), 32'd0);
    check("rst.y",  32'(outOffsetY), 32'd0);
    check_ovl("rst", 4'b0000, 1'b0);
    drawRequest  = '0;
    startOfFrame = 1'b0;
    resetN       = 1'b1;
    idle(1);

    // 2. Priority: ch1 beats ch3 (acc becomes 1010)
    pix("prio", 4'b1010, 4'b1111, 1'b0, 1'b1, 2'd1, 11'd100, 11'd50);

    // 3. Layer mask
    pix("mask_a", 4'b1010, 4'b1101, 1'b0, 1'b1, 2'd3, 11'd7, 11'd9);
    pix("mask_b", 4'b1010, 4'b0101, 1'b0, 1'b0, 2'd0, 11'd0, 11'd0);
    check_ovl("pre_sof", 4'b0000, 1'b0);

    // First SOF reports the 1010 overlap from step 2
    pix("sof0", 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 11'd0, 11'd0);
    check_ovl("sof0", 4'b1010, 1'b1);

    // 4. Overlap accumulation; snapshot must stay frame-stable meanwhile
    for (int k = 0; k < 3; k++) pix("f4_0011", 4'b0011, 4'b1111, 1'b0, 1'b1, 2'd0, 11'd11, 11'd22);
    for (int k = 0; k < 5; k++) pix("f4_0100", 4'b0100, 4'b1111, 1'b0, 1'b1, 2'd2, 11'd300, 11'd400);
    check_ovl("f4_stable", 4'b1010, 1'b1);
    pix("sof1", 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 11'd0, 11'd0);
    check_ovl("sof1", 4'b0011, 1'b1);
    idle(4);
    check_ovl("sof1_hold", 4'b0011, 1'b1);

    // 5. Hit on the SOF cycle belongs to the new frame
    pix("sof2", 4'b1100, 4'b1111, 1'b1, 1'b1, 2'd2, 11'd300, 11'd400);
    check_ovl("sof2", 4'b0000, 1'b0);
    idle(3);
    pix("sof3", 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 11'd0, 11'd0);
    check_ovl("sof3", 4'b1100, 1'b1);

    // Back-to-back SOF: zero-length frame reports only the previous cycle's hit
    pix("sof4", 4'b0011, 4'b1111, 1'b1, 1'b1, 2'd0, 11'd11, 11'd22);
    check_ovl("sof4", 4'b0000, 1'b0);
    pix("sof5", 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 11'd0, 11'd0);
    check_ovl("sof5", 4'b0011, 1'b1);

    // All channels requesting
    pix("all", 4'b1111, 4'b1111, 1'b0, 1'b1, 2'd0, 11'd11, 11'd22);
    pix("sof6", 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 11'd0, 11'd0);
    check_ovl("sof6", 4'b1111, 1'b1);

    // 6. Mid-frame reset discards the accumulator
    pix("acc0110", 4'b0110, 4'b1111, 1'b0, 1'b1, 2'd1, 11'd100, 11'd50);
    pix("acc0110", 4'b0110, 4'b1111, 1'b0, 1'b1, 2'd1, 11'd100, 11'd50);
    resetN = 1'b0;
    #2;
    check("arst.dr", 32'(outDrawRequest), 32'd0);
    check("arst.x",  32'(outOffsetX), 32'd0);
    check_ovl("arst", 4'b0000, 1'b0);
    drawRequest = 4'b0000;
    step();
    resetN = 1'b1;
    pix("sof7", 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 11'd0, 11'd0);
    check_ovl("sof7", 4'b0000, 1'b0);

    // Single requester (including one left alone by the enable mask) never overlaps
    pix("one_a", 4'b1000, 4'b1111, 1'b0, 1'b1, 2'd3, 11'd7, 11'd9);
    pix("one_b", 4'b0001, 4'b1111, 1'b0, 1'b1, 2'd0, 11'd11, 11'd22);
    pix("one_c", 4'b1111, 4'b0100, 1'b0, 1'b1, 2'd2, 11'd300, 11'd400);
    pix("sof8", 4'b0000, 4'b1111, 1'b1, 1'b0, 2'd0, 11'd0, 11'd0);
    check_ovl("sof8", 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
